// File: rtl/jtframe_rst_seq.sv
// Reset sequencer: PLL lock filter -> SDRAM init/download wait -> fixed game reset hold -> run.
// All outputs registered; lock loss, download and soft reset re-enter the sequence.
module jtframe_rst_seq #(
  parameter int LOCK_CYC = 1024,
  parameter int HOLD_CYC = 4096,
  parameter int CW       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       sdram_init,
  input  logic       dwnld,
  input  logic       soft_rst,
  output logic       game_rst,
  output logic       sdram_rst,
  output logic       boot_done,
  output logic [1:0] st
);

  localparam logic [1:0] S_LOCK  = 2'd0;
  localparam logic [1:0] S_SDRAM = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_RUN   = 2'd3;

  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    // Lock loss outranks everything once past the lock filter
    if (state_q != S_LOCK && !pll_locked) begin
      state_d = S_LOCK;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_LOCK: begin
          if (!pll_locked) begin
            cnt_d = '0;
          end else if (cnt_q == LOCK_LAST) begin
            state_d = S_SDRAM;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_SDRAM: begin
          cnt_d = '0;
          if (!sdram_init && !dwnld) state_d = S_HOLD;
        end
        S_HOLD: begin
          if (dwnld) begin
            state_d = S_SDRAM;
            cnt_d   = '0;
          end else if (soft_rst) begin
            cnt_d = '0;
          end else if (cnt_q == HOLD_LAST) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_RUN: begin
          cnt_d = '0;
          if (dwnld) begin
            state_d = S_SDRAM;
          end else if (soft_rst) begin
            state_d = S_HOLD;
          end
        end
        default: begin
          state_d = S_LOCK;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_LOCK;
      cnt_q     <= '0;
      game_rst  <= 1'b1;
      sdram_rst <= 1'b1;
      boot_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      game_rst  <= (state_d != S_RUN);
      sdram_rst <= (state_d == S_LOCK);
      boot_done <= (state_q == S_HOLD) && (state_d == S_RUN);
    end
  end

  assign st = state_q;

endmodule
